// File: rtl/filter_sequencer.sv
// Round-robin sequencer sharing one filter among NCH sample channels, one launch per PERIOD-clock slot.
// Optional FILTER_SEQ_STATS_EN adds saturating overrun/timeout counters.
module filter_sequencer #(
  parameter int DATA_W  = 16,
  parameter int NCH     = 4,
  parameter int PERIOD  = 50,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*DATA_W-1:0]   ch_data,
  output logic [NCH-1:0]          ch_ready,
  output logic [DATA_W-1:0]       flt_in_data,
  output logic                    flt_in_valid,
  input  logic [DATA_W-1:0]       flt_out_data,
  input  logic                    flt_out_valid,
  output logic [DATA_W-1:0]       res_data,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic                    res_valid,
  output logic                    busy,
  output logic                    timeout_err
`ifdef FILTER_SEQ_STATS_EN
  ,
  output logic [15:0]             overrun_cnt,
  output logic [15:0]             timeout_cnt
`endif
);
  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(PERIOD);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  logic [PW-1:0]       cnt;
  logic                tick;
  logic [CW-1:0]       gnt;
  logic [CW-1:0]       gnt_nxt;
  logic [CW-1:0]       idx;
  logic [7:0]          wcnt;
  logic [DATA_W-1:0]   ch_arr [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
  end

  assign tick = (cnt == PW'(PERIOD-1));

  // Scan from the farthest candidate back to the nearest so the first valid after gnt wins.
  always_comb begin
    gnt_nxt = gnt;
    idx     = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = CW'((int'(gnt) + k) % NCH);
      if (ch_valid[idx]) gnt_nxt = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= CW'(NCH-1);
      wcnt         <= '0;
      ch_ready     <= '0;
      flt_in_data  <= '0;
      flt_in_valid <= 1'b0;
      res_data     <= '0;
      res_ch       <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      cnt          <= tick ? '0 : cnt + PW'(1);
      ch_ready     <= '0;
      flt_in_valid <= 1'b0;
      res_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && |ch_valid) begin
            gnt   <= gnt_nxt;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          flt_in_valid <= 1'b1;
          flt_in_data  <= ch_arr[gnt];
          ch_ready     <= NCH'(1) << gnt;
          wcnt         <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // A result arriving on the timeout cycle still counts as a result.
          if (flt_out_valid) begin
            res_data  <= flt_out_data;
            res_ch    <= gnt;
            res_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (wcnt == 8'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILTER_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (tick && busy && |ch_valid && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
      if (timeout_err && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: scenario table, reset-in-WAIT sequence and randomized traffic
// checked cycle by cycle against a slot/latency timing model.
module tb_filter_sequencer;
  localparam int DW = 16, NCH = 4, P = 50, T = 255;
  localparam int NEVER = 1 << 30;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NCH-1:0]     ch_valid;
  logic [NCH*DW-1:0]  ch_data;
  logic [NCH-1:0]     ch_ready;
  logic [DW-1:0]      flt_in_data;
  logic               flt_in_valid;
  logic [DW-1:0]      flt_out_data;
  logic               flt_out_valid;
  logic [DW-1:0]      res_data;
  logic [1:0]         res_ch;
  logic               res_valid;
  logic               busy;
  logic               timeout_err;
`ifdef FILTER_SEQ_STATS_EN
  logic [15:0]        overrun_cnt;
  logic [15:0]        timeout_cnt;
`endif

  filter_sequencer #(.DATA_W(DW), .NCH(NCH), .PERIOD(P), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .flt_in_data(flt_in_data), .flt_in_valid(flt_in_valid),
    .flt_out_data(flt_out_data), .flt_out_valid(flt_out_valid),
    .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
    .busy(busy), .timeout_err(timeout_err)
`ifdef FILTER_SEQ_STATS_EN
    , .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, tc = 0;
  logic rst_q = 1'b1;

  // cyc = clocks since the last edge that saw reset; matches the DUT slot counter.
  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= reset ? 0 : cyc + 1;
    tc    <= tc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fmodel(input logic [DW-1:0] x);
    return 16'(x * 16'd3 + 16'h1357);
  endfunction

  // configuration written by the main sequence only
  logic [NCH-1:0] dir_mask = '0;
  int  fix_lat = 10;
  bit  rnd_mode = 1'b0;
  bit  clr_flt = 1'b1;

  // filter behaviour and reference model state, owned by the monitor
  bit  armed;
  int  due_tc;
  logic [DW-1:0] due_data;
  int  m_launch, m_res, m_to, m_done, m_from, m_g, m_ptr, m_ovr, m_tocnt;
  logic [DW-1:0] m_data;
  int  n_launch, n_res, n_to;
  int  glog[$];

  task automatic model_reset();
    m_launch = NEVER; m_res = NEVER; m_to = NEVER; m_from = NEVER; m_done = 0;
    m_g = 0; m_ptr = NCH - 1; m_ovr = 0; m_tocnt = 0; m_data = '0;
    n_launch = 0; n_res = 0; n_to = 0;
    glog.delete();
  endtask

  initial begin
    bit fo, e_fiv, e_res, e_to, e_busy, found;
    logic [DW-1:0] fo_d;
    logic [NCH-1:0] e_rdy;
    int lat, eff, g, id;
    flt_out_valid = 1'b0; flt_out_data = '0; ch_valid = '0; ch_data = '0;
    armed = 1'b0; due_tc = 0; due_data = '0;
    model_reset();
    forever begin
      @(negedge clk);
      fo = armed && (tc == due_tc);
      fo_d = due_data;
      if (fo) armed = 1'b0;
      // channel sources; the pending grant holds its data until ch_ready
      for (int i = 0; i < NCH; i++) begin
        if (!rnd_mode) begin
          ch_valid[i] = dir_mask[i];
          ch_data[i*DW +: DW] = 16'h4000 + 16'(i * 16'h0101);
        end else if (ch_ready[i]) begin
          ch_valid[i] = ($urandom_range(0, 3) != 0);
          ch_data[i*DW +: DW] = 16'($urandom);
        end else if (!(m_launch != NEVER && cyc < m_launch && i == m_g) && $urandom_range(0, 15) == 0) begin
          ch_valid[i] = ~ch_valid[i];
          ch_data[i*DW +: DW] = 16'($urandom);
        end
      end
      if (rst_q) begin
        chk("reset_outputs", {flt_in_valid, ch_ready, res_valid, timeout_err, busy, flt_in_data, res_data, res_ch}, 64'd0);
`ifdef FILTER_SEQ_STATS_EN
        chk("reset_stats", {overrun_cnt, timeout_cnt}, 64'd0);
`endif
        model_reset();
        if (clr_flt) armed = 1'b0;
      end else begin
        e_fiv  = (cyc == m_launch);
        e_res  = (cyc == m_res);
        e_to   = (cyc == m_to);
        e_busy = (cyc >= m_from) && (cyc < m_done);
        e_rdy  = e_fiv ? (NCH'(1) << m_g) : '0;
        chk("cycle_ctl", {flt_in_valid, ch_ready, res_valid, timeout_err, busy}, {e_fiv, e_rdy, e_res, e_to, e_busy});
        if (e_fiv) chk("launch_data", flt_in_data, m_data);
        if (e_res) begin
          chk("res_data", res_data, fmodel(m_data));
          chk("res_ch", res_ch, m_g);
        end
        n_launch += int'(flt_in_valid);
        n_res    += int'(res_valid);
        n_to     += int'(timeout_err);
        if (cyc == m_to + 1) m_tocnt++;
        if (flt_in_valid) begin
          id = 0;
          for (int i = 0; i < NCH; i++) if (ch_ready[i]) id = i;
          glog.push_back(id);
          if (rnd_mode) begin
            case ($urandom_range(0, 15))
              0: lat = 0;
              1: lat = T;
              default: lat = $urandom_range(1, 70);
            endcase
          end else lat = fix_lat;
          if (lat > 0) begin
            armed = 1'b1; due_tc = tc + lat; due_data = fmodel(flt_in_data);
          end
          if (e_fiv) begin
            eff = (lat == 0 || lat > T) ? T : lat;
            if (lat > 0 && lat <= T) begin m_res = cyc + lat + 1; m_to = NEVER; end
            else begin m_to = cyc + T + 1; m_res = NEVER; end
            m_done = cyc + eff + 1;
          end
        end
        // stray filter strobes while the sequencer is not waiting
        if (rnd_mode && !fo && !armed && cyc >= m_done && $urandom_range(0, 7) == 0) begin
          fo = 1'b1; fo_d = 16'($urandom);
        end
        if (cyc % P == P - 1) begin
          if (cyc < m_done) begin
            if (|ch_valid) m_ovr++;
          end else if (|ch_valid) begin
            found = 1'b0; g = 0;
            for (int k = 1; k <= NCH; k++)
              if (!found && ch_valid[(m_ptr + k) % NCH]) begin found = 1'b1; g = (m_ptr + k) % NCH; end
            m_g = g; m_ptr = g; m_data = ch_data[g*DW +: DW];
            m_launch = cyc + 2; m_from = cyc + 1; m_done = NEVER;
          end
        end
      end
      flt_out_valid = fo;
      flt_out_data  = fo ? fo_d : '0;
    end
  end

  task automatic run_scn(input logic [NCH-1:0] mask, input int lat, input int ncyc, input bit rnd);
    @(negedge clk);
    dir_mask = mask; fix_lat = lat; rnd_mode = rnd; clr_flt = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_stats();
`ifdef FILTER_SEQ_STATS_EN
    chk("overrun_cnt", overrun_cnt, m_ovr);
    chk("timeout_cnt", timeout_cnt, m_tocnt);
`endif
  endtask

  typedef struct {
    logic [NCH-1:0] mask;
    int lat, ncyc, e_l, e_r, e_t;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int first, nres, rdy, guard;
    tbl[0] = '{4'b0001, 10,  300, 5, 5, 0};  // single channel, latency 10
    tbl[1] = '{4'b1111, 10,  300, 5, 5, 0};  // all channels, round robin
    tbl[2] = '{4'b0001, 60,  300, 3, 2, 0};  // latency > PERIOD, every other tick lost
    tbl[3] = '{4'b0011, 0,   600, 2, 0, 1};  // filter never answers
    tbl[4] = '{4'b0001, T,   600, 2, 1, 0};  // answer on the timeout cycle
    tbl[5] = '{4'b0000, 10,  300, 0, 0, 0};  // nothing requested
    for (int i = 0; i < 6; i++) begin
      run_scn(tbl[i].mask, tbl[i].lat, tbl[i].ncyc, 1'b0);
      chk($sformatf("tbl%0d_launches", i), n_launch, tbl[i].e_l);
      chk($sformatf("tbl%0d_results", i), n_res, tbl[i].e_r);
      chk($sformatf("tbl%0d_timeouts", i), n_to, tbl[i].e_t);
      chk_stats();
      if (i == 1) begin
        chk("rr_log_len", glog.size(), 5);
        for (int j = 0; j < 5 && j < glog.size(); j++) chk($sformatf("rr_grant%0d", j), glog[j], j % NCH);
      end
    end

    run_scn('0, 0, 20000, 1'b1);
    chk("rnd_activity", n_launch > 100, 1);
    chk_stats();

    // reset in WAIT; the filter answers 3 clocks after reset is first sampled
    @(negedge clk);
    dir_mask = 4'b0001; fix_lat = 10; rnd_mode = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    guard = 0;
    while (cyc != 58 && guard < 200) begin @(negedge clk); guard++; end
    chk("rst_wait_reached", cyc, 58);
    clr_flt = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wait_outputs", {flt_in_valid, ch_ready, res_valid, timeout_err, busy, flt_in_data, res_data, res_ch}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    first = -1; nres = 0; rdy = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (flt_in_valid && first < 0) begin first = cyc; rdy = int'(ch_ready); end
      if (res_valid) nres++;
    end
    chk("rst_no_late_result", nres, 0);
    chk("rst_first_launch_cyc", first, P + 1);
    chk("rst_first_launch_ch0", rdy, 1);
    clr_flt = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
